// File: rtl/key_debounce.sv
// Per-key debouncer and edge detector for the front-panel keys.
// Each channel: 2-flop synchroniser, qualification counter, stable level,
// registered press/release pulses and a press-driven toggle.
module key_debounce #(
    parameter int unsigned N             = 8,
    parameter int unsigned STABLE_CYCLES = 60000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] keys_raw,
    output logic [N-1:0] keys_stable,
    output logic [N-1:0] keys_pressed,
    output logic [N-1:0] keys_released,
    output logic [N-1:0] keys_toggle
);

    localparam int unsigned CntW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

    logic [N-1:0]    s1_q, s2_q;
    logic [CntW-1:0] cnt_q [N];
    logic [CntW-1:0] cnt_d [N];
    logic [N-1:0]    stable_q, stable_d;
    logic [N-1:0]    pressed_q, pressed_d;
    logic [N-1:0]    released_q, released_d;
    logic [N-1:0]    toggle_q, toggle_d;

    // Two-stage synchroniser for the asynchronous raw key levels.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= keys_raw;
            s2_q <= s1_q;
        end
    end

    // Per-channel qualification: count cycles of disagreement, accept on the last one.
    always_comb begin
        stable_d   = stable_q;
        pressed_d  = '0;
        released_d = '0;
        toggle_d   = toggle_q;
        for (int unsigned i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == stable_q[i]) begin
                // Any bounce back to the stable level restarts qualification.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
                if (s2_q[i]) begin
                    pressed_d[i] = 1'b1;
                    toggle_d[i]  = ~toggle_q[i];
                end else begin
                    released_d[i] = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    // State and output registers; every output is a direct flop output.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q   <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            toggle_q   <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q   <= stable_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            toggle_q   <= toggle_d;
        end
    end

    assign keys_stable   = stable_q;
    assign keys_pressed  = pressed_q;
    assign keys_released = released_q;
    assign keys_toggle   = toggle_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: a small-parameter instance checked every cycle
// against a hold-time model plus directed literals, and a default-parameter
// instance exercised with long glitch/hold patterns in parallel.
module tb_key_debounce;

    localparam int N  = 8;
    localparam int SC = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [N-1:0] keys_raw = '1;
    logic [N-1:0] keys_stable, keys_pressed, keys_released, keys_toggle;

    logic reset_big = 1'b0;
    logic [N-1:0] keys_big = '0;
    logic [N-1:0] big_stable, big_pressed, big_released, big_toggle;

    int  n_checks = 0;
    int  n_fail   = 0;
    logic big_done = 1'b0;

    always #5 clock = ~clock;

    key_debounce #(.N(N), .STABLE_CYCLES(SC)) dut (
        .clock         (clock),
        .reset         (reset),
        .keys_raw      (keys_raw),
        .keys_stable   (keys_stable),
        .keys_pressed  (keys_pressed),
        .keys_released (keys_released),
        .keys_toggle   (keys_toggle)
    );

    key_debounce #(.N(N)) dut_big (
        .clock         (clock),
        .reset         (reset_big),
        .keys_raw      (keys_big),
        .keys_stable   (big_stable),
        .keys_pressed  (big_pressed),
        .keys_released (big_released),
        .keys_toggle   (big_toggle)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n falling edges, then step 1 time unit so input changes stay off the edges.
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    // Model: the synchronised stream (raw delayed two edges) is accepted once it
    // has held a level different from the stable value for SC consecutive edges.
    logic [N-1:0] m_s1, m_s2, m_cur, m_last, m_stable, m_press, m_rel, m_tog;
    int           m_run [N];

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                m_s1 = '0; m_s2 = '0; m_last = '0; m_stable = '0;
                m_press = '0; m_rel = '0; m_tog = '0;
                for (int i = 0; i < N; i++) m_run[i] = 0;
            end else begin
                m_cur   = m_s2;
                m_press = '0;
                m_rel   = '0;
                for (int i = 0; i < N; i++) begin
                    m_run[i] = (m_cur[i] == m_last[i]) ? m_run[i] + 1 : 1;
                    if (m_cur[i] != m_stable[i] && m_run[i] >= SC) begin
                        m_stable[i] = m_cur[i];
                        if (m_cur[i]) begin
                            m_press[i] = 1'b1;
                            m_tog[i]   = ~m_tog[i];
                        end else begin
                            m_rel[i] = 1'b1;
                        end
                    end
                end
                m_last = m_cur;
                m_s2   = m_s1;
                m_s1   = keys_raw;
            end
            check("model_stable",   32'(keys_stable),   32'(m_stable));
            check("model_pressed",  32'(keys_pressed),  32'(m_press));
            check("model_released", 32'(keys_released), 32'(m_rel));
            check("model_toggle",   32'(keys_toggle),   32'(m_tog));
        end
    end

    // Default-parameter instance: 59000-cycle glitch on key 0, 61000-cycle hold on key 1.
    initial begin
        int glitch_press;
        int press1_cnt;
        int press1_edge;
        int rel_cnt;
        glitch_press = 0; press1_cnt = 0; press1_edge = -1; rel_cnt = 0;
        cyc(2);
        reset_big = 1'b1;
        keys_big  = 8'h03;
        for (int e = 1; e <= 61000; e++) begin
            @(negedge clock);
            if (big_pressed[0]) glitch_press++;
            if (big_pressed[1]) begin
                press1_cnt++;
                press1_edge = e;
            end
            if (big_released != '0) rel_cnt++;
            if (e == 59000) begin
                #1 keys_big[0] = 1'b0;
            end
        end
        check("big_glitch_press", 32'(glitch_press), 32'd0);
        check("big_press_count",  32'(press1_cnt),   32'd1);
        check("big_press_edge",   32'(press1_edge),  32'd60002);
        check("big_released",     32'(rel_cnt),      32'd0);
        check("big_stable",       32'(big_stable),   32'h02);
        check("big_toggle",       32'(big_toggle),   32'h02);
        big_done = 1'b1;
    end

    initial begin
        // Keys held through reset; release then expect a press 6 edges later.
        cyc(3);
        reset = 1'b1;
        cyc(5);
        check("rst_press_early", 32'(keys_pressed), 32'h00);
        cyc(1);
        check("rst_press_edge6", 32'(keys_pressed), 32'hFF);
        check("rst_stable_edge6", 32'(keys_stable), 32'hFF);
        cyc(1);
        check("rst_press_single", 32'(keys_pressed), 32'h00);
        cyc(3);
        // Asynchronous clear, checked before any clock edge.
        reset = 1'b0;
        #1;
        check("async_stable", 32'(keys_stable), 32'h00);
        check("async_toggle", 32'(keys_toggle), 32'h00);
        cyc(2);
        reset = 1'b1;
        cyc(6);
        check("rehold_press", 32'(keys_pressed), 32'hFF);
        keys_raw = 8'h00;
        cyc(6);
        check("all_release", 32'(keys_released), 32'hFF);
        cyc(2);
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(2);

        // Clean press and release of key 6.
        keys_raw = 8'h40;
        cyc(5);
        check("k6_press_early", 32'(keys_pressed), 32'h00);
        cyc(1);
        check("k6_press", 32'(keys_pressed), 32'h40);
        check("k6_toggle", 32'(keys_toggle), 32'h40);
        cyc(14);
        keys_raw = 8'h00;
        cyc(6);
        check("k6_release", 32'(keys_released), 32'h40);
        check("k6_toggle_kept", 32'(keys_toggle), 32'h40);
        cyc(2);

        // Bounce on key 2: only the final steady rise qualifies.
        keys_raw = 8'h04; cyc(3);
        keys_raw = 8'h00; cyc(1);
        keys_raw = 8'h04; cyc(2);
        keys_raw = 8'h00; cyc(1);
        keys_raw = 8'h04;
        cyc(5);
        check("k2_press_early", 32'(keys_pressed), 32'h00);
        cyc(1);
        check("k2_press", 32'(keys_pressed), 32'h04);
        cyc(4);

        // Keys 4 and 6 press while key 2 releases in the same cycle.
        keys_raw = 8'h50;
        cyc(6);
        check("sim_press", 32'(keys_pressed), 32'h50);
        check("sim_release", 32'(keys_released), 32'h04);
        cyc(3);

        // A 5-cycle pulse on key 1 is long enough to be accepted.
        keys_raw = 8'h52;
        cyc(5);
        keys_raw = 8'h50;
        cyc(1);
        check("k1_short_press", 32'(keys_pressed), 32'h02);
        cyc(5);
        check("k1_short_release", 32'(keys_released), 32'h02);
        cyc(2);

        // Reset in the middle of qualifying key 0.
        keys_raw = 8'h00;
        cyc(8);
        keys_raw = 8'h01;
        cyc(4);
        check("k0_no_early_press", 32'(keys_pressed), 32'h00);
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(5);
        check("k0_press_early", 32'(keys_pressed), 32'h00);
        cyc(1);
        check("k0_press", 32'(keys_pressed), 32'h01);
        check("k0_toggle", 32'(keys_toggle), 32'h01);
        cyc(2);

        wait (big_done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
